// File: rtl/muldiv_stall_ctrl_if.sv
// Handshake/bus bundle between the EX/ID pipeline logic and the HI/LO
// multiply/divide sequencer with its front-end stall arbitration.
interface muldiv_stall_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             EX_MulDivStart;
  logic [1:0]       EX_MulDivOp;
  logic [WIDTH-1:0] EX_rs_data;
  logic [WIDTH-1:0] EX_rt_data;
  logic             ID_MulDiv;
  logic             ID_ReadHiLo;
  logic             LoadUse_Stall;
  logic             PC_WriteEn;
  logic             IFID_WriteEn;
  logic             Stall_flush;
  logic             MD_Busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             DivByZero;

  // Pipeline side: issues operations and hazard requests, consumes stalls/results
  modport master (
    output EX_MulDivStart, EX_MulDivOp, EX_rs_data, EX_rt_data,
    output ID_MulDiv, ID_ReadHiLo, LoadUse_Stall,
    input  PC_WriteEn, IFID_WriteEn, Stall_flush, MD_Busy, HI, LO, DivByZero
  );

  // Sequencer side
  modport slave (
    input  EX_MulDivStart, EX_MulDivOp, EX_rs_data, EX_rt_data,
    input  ID_MulDiv, ID_ReadHiLo, LoadUse_Stall,
    output PC_WriteEn, IFID_WriteEn, Stall_flush, MD_Busy, HI, LO, DivByZero
  );
endinterface

// File: rtl/muldiv_stall_ctrl.sv
// Iterative HI/LO multiply/divide sequencer (MULTU/MULT/DIVU/DIV, one bit per
// cycle) plus front-end stall arbitration merging load-use and HI/LO hazards.
// Optional feature macro: MULDIV_DIVZERO_FLAG_EN builds the one-cycle
// divide-by-zero flag; without it DivByZero is tied low.
module muldiv_stall_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  muldiv_stall_ctrl_if.slave  md_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             div_q;    // operation is a divide
  logic             sa_q;     // operand A was negative (signed op)
  logic             neg_q;    // result (product / quotient) must be negated
  logic             dz_q;     // divide by zero: results preloaded, no iteration
  logic [WIDTH-1:0] opnd_q;   // |A| for multiply (addend), |B| for divide (divisor)
  logic [WIDTH-1:0] rem_q;    // product upper half / partial remainder
  logic [WIDTH-1:0] quo_q;    // multiplier bits + product lower half / quotient
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             start_div;
  logic             start_sgn;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;
  logic             busy_c;
  logic             stall_c;

  // Operand magnitudes captured at start (abs only for signed ops)
  always_comb begin
    start_div = md_if.EX_MulDivOp[1];
    start_sgn = md_if.EX_MulDivOp[0];
    abs_a     = (start_sgn && md_if.EX_rs_data[WIDTH-1]) ? -md_if.EX_rs_data : md_if.EX_rs_data;
    abs_b     = (start_sgn && md_if.EX_rt_data[WIDTH-1]) ? -md_if.EX_rt_data : md_if.EX_rt_data;
  end

  // One iteration step: shift-add multiply or restoring shift-subtract divide
  always_comb begin
    mul_sum   = {1'b0, rem_q} + {1'b0, (quo_q[0] ? opnd_q : '0)};
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ok    = ~div_diff[WIDTH];
    rem_d     = mul_sum[WIDTH:1];
    quo_d     = {mul_sum[0], quo_q[WIDTH-1:1]};
    if (div_q) begin
      rem_d = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], div_ok};
    end
  end

  // Sign fix-up applied on the FIX edge
  always_comb begin
    prod_fix = neg_q ? -{rem_q, quo_q} : {rem_q, quo_q};
    hi_d     = prod_fix[2*WIDTH-1:WIDTH];
    lo_d     = prod_fix[WIDTH-1:0];
    if (dz_q) begin
      hi_d = rem_q;
      lo_d = quo_q;
    end else if (div_q) begin
      hi_d = sa_q  ? -rem_q : rem_q;
      lo_d = neg_q ? -quo_q : quo_q;
    end
  end

  // Sequencer FSM and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      opnd_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (md_if.EX_MulDivStart) begin
            div_q <= start_div;
            sa_q  <= start_sgn & md_if.EX_rs_data[WIDTH-1];
            neg_q <= start_sgn & (md_if.EX_rs_data[WIDTH-1] ^ md_if.EX_rt_data[WIDTH-1]);
            cnt_q <= '0;
            if (start_div && (md_if.EX_rt_data == '0)) begin
              dz_q    <= 1'b1;
              rem_q   <= md_if.EX_rs_data;
              quo_q   <= '1;
              opnd_q  <= '0;
              state_q <= S_FIX;
            end else begin
              dz_q    <= 1'b0;
              rem_q   <= '0;
              quo_q   <= start_div ? abs_a : abs_b;
              opnd_q  <= start_div ? abs_b : abs_a;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MULDIV_DIVZERO_FLAG_EN
  logic dz_flag_q;

  // Divide-by-zero flag: high for the single cycle following the FIX edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dz_flag_q <= 1'b0;
    end else begin
      dz_flag_q <= (state_q == S_FIX) && dz_q;
    end
  end

  assign md_if.DivByZero = dz_flag_q;
`else
  assign md_if.DivByZero = 1'b0;
`endif

  // Stall arbitration: HI/LO hazard hold merged with load-use request
  always_comb begin
    busy_c  = (state_q != S_IDLE);
    stall_c = (busy_c & (md_if.ID_MulDiv | md_if.ID_ReadHiLo)) | md_if.LoadUse_Stall;
  end

  assign md_if.MD_Busy      = busy_c;
  assign md_if.PC_WriteEn   = ~stall_c;
  assign md_if.IFID_WriteEn = ~stall_c;
  assign md_if.Stall_flush  = stall_c;
  assign md_if.HI           = hi_q;
  assign md_if.LO           = lo_q;

endmodule

// File: tb/tb_muldiv_stall_ctrl.sv
// Bench for muldiv_stall_ctrl: directed vectors, randomized operations against
// a 64-bit arithmetic reference model, stall arbitration and reset-abort cases.
module tb_muldiv_stall_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  muldiv_stall_ctrl_if #(.WIDTH(32)) md_if ();

  muldiv_stall_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .md_if (md_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Stall outputs as one vector {PC_WriteEn, IFID_WriteEn, Stall_flush}
  task automatic chk_stall(input string tag, input bit stall);
    chk(tag, 32'({md_if.PC_WriteEn, md_if.IFID_WriteEn, md_if.Stall_flush}),
        32'({~stall, ~stall, stall}));
  endtask

  // Reference {HI, LO} from plain 64-bit arithmetic
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    model = '0;
    if (op[1] && (b == 32'd0)) begin
      model = {a, 32'hFFFF_FFFF};
    end else begin
      case (op)
        2'b00: model = ua * ub;
        2'b01: model = sa * sb;
        2'b10: begin uq = ua / ub; ur = ua % ub; model = {ur[31:0], uq[31:0]}; end
        default: begin sq = sa / sb; sr = sa % sb; model = {sr[31:0], sq[31:0]}; end
      endcase
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: pick = 32'd0;
      1: pick = 32'd1;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'h8000_0000;
      4: pick = 32'h7FFF_FFFF;
      5: pick = 32'($urandom_range(0, 15));
      default: pick = $urandom();
    endcase
  endfunction

  // Issue a start pulse sampled at edge E0; returns #1 after E0
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_if.EX_MulDivStart = 1'b1;
    md_if.EX_MulDivOp    = op;
    md_if.EX_rs_data     = a;
    md_if.EX_rt_data     = b;
    @(posedge clk);
    #1;
    md_if.EX_MulDivStart = 1'b0;
    md_if.EX_rs_data     = $urandom();
    md_if.EX_rt_data     = $urandom();
  endtask

  // Full operation with latency, hold-until-FIX and result checks
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [63:0] r;
    bit dz;
    r  = model(op, a, b);
    dz = op[1] && (b == 32'd0);
    issue(op, a, b);
    chk({tag, "/busy_e0"}, 32'(md_if.MD_Busy), 32'd1);
    if (dz) begin
      @(posedge clk); #1;
`ifdef MULDIV_DIVZERO_FLAG_EN
      chk({tag, "/dz_flag_e1"}, 32'(md_if.DivByZero), 32'd1);
`else
      chk({tag, "/dz_flag_e1"}, 32'(md_if.DivByZero), 32'd0);
`endif
      @(posedge clk); #1;
      chk({tag, "/dz_flag_e2"}, 32'(md_if.DivByZero), 32'd0);
      chk({tag, "/busy_e2"}, 32'(md_if.MD_Busy), 32'd0);
    end else begin
      repeat (32) @(posedge clk);
      #1;
      chk({tag, "/busy_e32"}, 32'(md_if.MD_Busy), 32'd1);
      chk({tag, "/hi_hold_e32"}, md_if.HI, exp_hi);
      chk({tag, "/lo_hold_e32"}, md_if.LO, exp_lo);
      @(posedge clk); #1;
      chk({tag, "/busy_e33"}, 32'(md_if.MD_Busy), 32'd0);
      chk({tag, "/dz_flag"}, 32'(md_if.DivByZero), 32'd0);
    end
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    chk({tag, "/hi"}, md_if.HI, exp_hi);
    chk({tag, "/lo"}, md_if.LO, exp_lo);
  endtask

  // MULTU 5*6 with ID-stage hazards applied; kind 0 MFHI, 1 ADD, 2 load-use + mult
  task automatic stall_test(input int kind, input string tag);
    bit idm, idr, lu, busy;
    idm = 1'b0; idr = 1'b0; lu = 1'b0;
    issue(2'b00, 32'd5, 32'd6);
    for (int e = 1; e <= 33; e++) begin
      @(posedge clk); #1;
      if (e == 5) begin
        idr = (kind == 0);
        idm = (kind == 2);
        lu  = (kind == 2);
      end
      if (kind == 2 && e == 10) idm = 1'b0;
      if (kind == 2 && e == 12) lu  = 1'b0;
      md_if.ID_MulDiv     = idm;
      md_if.ID_ReadHiLo   = idr;
      md_if.LoadUse_Stall = lu;
      #1;
      busy = (e <= 32);
      if (e == 5 || e == 11 || e == 12 || e == 32 || e == 33)
        chk_stall($sformatf("%s/stall_e%0d", tag, e), (busy && (idm || idr)) || lu);
    end
    exp_hi = 32'd0;
    exp_lo = 32'd30;
    chk({tag, "/lo"}, md_if.LO, exp_lo);
    md_if.ID_MulDiv   = 1'b0;
    md_if.ID_ReadHiLo = 1'b0;
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    reset                = 1'b1;
    md_if.EX_MulDivStart = 1'b0;
    md_if.EX_MulDivOp    = 2'b00;
    md_if.EX_rs_data     = '0;
    md_if.EX_rt_data     = '0;
    md_if.ID_MulDiv      = 1'b0;
    md_if.ID_ReadHiLo    = 1'b0;
    md_if.LoadUse_Stall  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/busy", 32'(md_if.MD_Busy), 32'd0);
    chk("rst/hi", md_if.HI, 32'd0);
    chk("rst/lo", md_if.LO, 32'd0);
    chk("rst/dz_flag", 32'(md_if.DivByZero), 32'd0);
    chk_stall("rst/no_stall", 1'b0);
    md_if.LoadUse_Stall = 1'b1;
    #1;
    chk_stall("rst/loaduse_stall", 1'b1);
    md_if.LoadUse_Stall = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    run_op(2'b00, 32'hFFFF_FFFF, 32'd2, "multu_max");
    run_op(2'b01, -32'sd3, 32'd7, "mult_neg");
    run_op(2'b11, -32'sd7, 32'd2, "div_neg");
    run_op(2'b10, 32'd100, 32'd7, "divu");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'b10, 32'h1234_5678, 32'd0, "divu_zero");
    run_op(2'b11, -32'sd9, 32'd0, "div_zero");
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, "mult_minmin");

    stall_test(0, "mfhi");
    stall_test(1, "alu");
    stall_test(2, "loaduse");

    run_op(2'b11, -32'sd7, 32'd2, "pre_rst");
    issue(2'b10, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    chk("abort/busy", 32'(md_if.MD_Busy), 32'd0);
    chk("abort/hi", md_if.HI, exp_hi);
    chk("abort/lo", md_if.LO, exp_lo);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      run_op(op, a, b, $sformatf("rnd%0d_op%0d", i, op));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
